ccc_csr_writeback: RTL and testbench

Collects configuration changes made on the bus by CCCs (dynamic address assignment via ENTDAA/SETDASA/SETNEWDA, RSTDAA, SETMWL, SETMRL) and writes them back into the standby-controller / TTI register file through a single-request write port. Sits between the target CCC handler and the CSR block. The CSRs stay the single source of truth that the configuration extractor reads. Pending updates are buffered per kind, arbitrated by fixed priority, and handed off with a req/ack handshake.

---
 rtl/ccc_csr_writeback_if.sv | 11 +
 rtl/ccc_csr_writeback.sv | 177 +++++++++++++++++
 tb/tb_ccc_csr_writeback.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccc_csr_writeback_if.sv
// Single-request CSR write port between the CCC writeback block (master)
// and the standby-controller / TTI register file (slave).
interface ccc_csr_writeback_if;
    logic        req;
    logic [2:0]  sel;
    logic [15:0] data;
    logic        ack;

    modport master (output req, output sel, output data, input ack);
    modport slave  (input req, input sel, input data, output ack);
endinterface

// File: rtl/ccc_csr_writeback.sv
// Buffers CCC-driven configuration changes (one slot per kind) and writes
// them one at a time into the CSR block through a req/ack port.
module ccc_csr_writeback #(
    parameter int unsigned AckTimeout = 0,
    parameter int unsigned TimeoutW   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_dyn_addr_i,
    input  logic [6:0]          dyn_addr_i,
    input  logic                set_virt_dyn_addr_i,
    input  logic [6:0]          virt_dyn_addr_i,
    input  logic                rstdaa_i,
    input  logic                set_mwl_i,
    input  logic [15:0]         mwl_i,
    input  logic                set_mrl_i,
    input  logic [15:0]         mrl_i,
    input  logic                clear_status_i,
    ccc_csr_writeback_if.master csr,
    output logic                busy_o,
    output logic [4:0]          overflow_o,
    output logic                timeout_o
);
    localparam bit TimeoutEn = (AckTimeout != 0);
    localparam logic [TimeoutW-1:0] TimeoutLast =
        TimeoutEn ? TimeoutW'(AckTimeout - 1) : '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Address kinds are written as {8'h00, valid, addr}.
    function automatic logic [15:0] addr_word(input logic [6:0] addr);
        return {8'h00, 1'b1, addr};
    endfunction

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [2:0]         sel_q, sel_d;
    logic [15:0]        data_q, data_d;
    logic [TimeoutW-1:0] cnt_q, cnt_d;
    logic [4:0]         pend_q, pend_d;
    logic [4:0][15:0]   slot_q, slot_d;
    logic [4:0]         ovf_q, ovf_d;
    logic               tout_q, tout_d;

    logic [4:0]         set_s;
    logic [4:0][15:0]   payload_s;
    logic [4:0]         cancel_s;
    logic               win_valid_s;
    logic [2:0]         win_sel_s;
    logic [15:0]        win_data_s;
    logic [4:0]         load_s;
    logic               tout_fire_s;
    logic [4:0]         ovf_set_s;

    // Event decode: index of each bit is the CSR select code of that kind.
    always_comb begin
        set_s        = {set_mrl_i, set_mwl_i, set_virt_dyn_addr_i, set_dyn_addr_i, rstdaa_i};
        payload_s[0] = 16'h0000;
        payload_s[1] = addr_word(dyn_addr_i);
        payload_s[2] = addr_word(virt_dyn_addr_i);
        payload_s[3] = mwl_i;
        payload_s[4] = mrl_i;
        // RSTDAA drops queued address writes, but not one issued this cycle alongside it.
        cancel_s     = {2'b00, rstdaa_i, rstdaa_i, 1'b0};
    end

    // Fixed-priority pick of the lowest pending kind.
    always_comb begin
        win_valid_s = 1'b1;
        win_sel_s   = 3'd0;
        win_data_s  = 16'h0000;
        casez (pend_q)
            5'b????1: begin win_sel_s = 3'd0; win_data_s = slot_q[0]; end
            5'b???10: begin win_sel_s = 3'd1; win_data_s = slot_q[1]; end
            5'b??100: begin win_sel_s = 3'd2; win_data_s = slot_q[2]; end
            5'b?1000: begin win_sel_s = 3'd3; win_data_s = slot_q[3]; end
            5'b10000: begin win_sel_s = 3'd4; win_data_s = slot_q[4]; end
            default:  begin win_valid_s = 1'b0; end
        endcase
    end

    // Request FSM: load from the pending buffer in IDLE, hold until ack or timeout.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        sel_d       = sel_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        load_s      = 5'b00000;
        tout_fire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    sel_d   = win_sel_s;
                    data_d  = win_data_s;
                    cnt_d   = '0;
                    load_s  = 5'b00001 << win_sel_s;
                end else begin
                    req_d   = 1'b0;
                end
            end
            ST_REQ: begin
                if (csr.ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                    state_d     = ST_IDLE;
                    req_d       = 1'b0;
                    tout_fire_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + TimeoutW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Pending buffer and sticky status; a slot being loaded this edge is not an overwrite.
    always_comb begin
        pend_d    = set_s | (pend_q & ~load_s & ~cancel_s);
        ovf_set_s = set_s & pend_q & ~load_s & ~cancel_s;
        for (int k = 0; k < 5; k++) begin
            if (set_s[k]) begin
                slot_d[k] = payload_s[k];
            end else begin
                slot_d[k] = slot_q[k];
            end
        end
        if (clear_status_i) begin
            ovf_d  = ovf_set_s;
            tout_d = tout_fire_s;
        end else begin
            ovf_d  = ovf_q | ovf_set_s;
            tout_d = tout_q | tout_fire_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            sel_q   <= 3'd0;
            data_q  <= 16'h0000;
            cnt_q   <= '0;
            pend_q  <= 5'b00000;
            slot_q  <= '0;
            ovf_q   <= 5'b00000;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            slot_q  <= slot_d;
            ovf_q   <= ovf_d;
            tout_q  <= tout_d;
        end
    end

    assign csr.req    = req_q;
    assign csr.sel    = sel_q;
    assign csr.data   = data_q;
    assign busy_o     = req_q | (|pend_q);
    assign overflow_o = ovf_q;
    assign timeout_o  = tout_q;
endmodule

// File: tb/tb_ccc_csr_writeback.sv
// Bench for ccc_csr_writeback: vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_ccc_csr_writeback;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        set_dyn, set_virt, rstdaa, set_mwl, set_mrl, clr;
    logic [6:0]  dyn_addr, virt_addr;
    logic [15:0] mwl, mrl;
    logic        ack0, ack1;
    logic        busy0, busy1, tout0, tout1;
    logic [4:0]  ovf0, ovf1;

    ccc_csr_writeback_if bus0();
    ccc_csr_writeback_if bus1();
    assign bus0.ack = ack0;
    assign bus1.ack = ack1;

    ccc_csr_writeback #(.AckTimeout(0), .TimeoutW(16)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .set_dyn_addr_i(set_dyn), .dyn_addr_i(dyn_addr),
        .set_virt_dyn_addr_i(set_virt), .virt_dyn_addr_i(virt_addr),
        .rstdaa_i(rstdaa), .set_mwl_i(set_mwl), .mwl_i(mwl),
        .set_mrl_i(set_mrl), .mrl_i(mrl), .clear_status_i(clr),
        .csr(bus0), .busy_o(busy0), .overflow_o(ovf0), .timeout_o(tout0));

    ccc_csr_writeback #(.AckTimeout(4), .TimeoutW(16)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .set_dyn_addr_i(set_dyn), .dyn_addr_i(dyn_addr),
        .set_virt_dyn_addr_i(set_virt), .virt_dyn_addr_i(virt_addr),
        .rstdaa_i(rstdaa), .set_mwl_i(set_mwl), .mwl_i(mwl),
        .set_mrl_i(set_mrl), .mrl_i(mrl), .clear_status_i(clr),
        .csr(bus1), .busy_o(busy1), .overflow_o(ovf1), .timeout_o(tout1));

    localparam logic [4:0] EV_RST = 5'b00001, EV_DYN = 5'b00010, EV_VIRT = 5'b00100,
                           EV_MWL = 5'b01000, EV_MRL = 5'b10000, EV_NONE = 5'b00000;

    typedef struct {
        logic [4:0]  ev;
        logic [6:0]  addr;
        logic [15:0] len;
        logic        ack;
        logic        clr;
        logic        e_req;
        logic [2:0]  e_sel;
        logic [15:0] e_data;
        logic        e_busy;
        logic [4:0]  e_ovf;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] ev, input logic [6:0] a, input logic [6:0] va,
                         input logic [15:0] wl, input logic [15:0] rl, input logic c);
        rstdaa = ev[0]; set_dyn = ev[1]; set_virt = ev[2]; set_mwl = ev[3]; set_mrl = ev[4];
        dyn_addr = a; virt_addr = va; mwl = wl; mrl = rl; clr = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(EV_NONE, 7'h00, 7'h00, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic add(input logic [4:0] ev, input logic [6:0] a, input logic [15:0] l,
                       input logic ak, input logic c, input logic er, input logic [2:0] es,
                       input logic [15:0] ed, input logic eb, input logic [4:0] eo);
        vec_t v;
        v.ev = ev; v.addr = a; v.len = l; v.ack = ak; v.clr = c;
        v.e_req = er; v.e_sel = es; v.e_data = ed; v.e_busy = eb; v.e_ovf = eo;
        vq.push_back(v);
    endtask

    // Reference model state: pending flag and latest payload per kind, plus the write in flight.
    bit          m_pend [5];
    logic [15:0] m_val  [5];
    bit          m_fly;
    logic [2:0]  m_sel;
    logic [15:0] m_data;
    logic [4:0]  m_ovf;

    function automatic logic [15:0] payload(input int k, input logic [6:0] a, input logic [6:0] va,
                                            input logic [15:0] wl, input logic [15:0] rl);
        case (k)
            1:       return {8'h00, 1'b1, a};
            2:       return {8'h00, 1'b1, va};
            3:       return wl;
            4:       return rl;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        int hi_cnt;
        int first_hi;
        logic [25:0] act_t, exp_t;

        ack0 = 1'b1;
        ack1 = 1'b0;
        do_reset();

        check("reset_dut0", {bus0.req, bus0.sel, bus0.data, busy0, ovf0, tout0}, 64'd0);
        check("reset_dut1", {bus1.req, bus1.sel, bus1.data, busy1, ovf1, tout1}, 64'd0);

        // Single SETDASA with ack held high.
        add(EV_DYN, 7'h2A, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 16'h00AA, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        // Simultaneous RSTDAA + SETDASA + SETMWL: priority order, two cycles apart.
        add(EV_RST | EV_DYN | EV_MWL, 7'h10, 16'h0100, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0090, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0100, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        // MWL overwritten while an MRL write waits for ack; then clear_status.
        add(EV_MRL, 7'h00, 16'h0055, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_MWL, 7'h00, 16'h0040, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0055, 1'b1, 5'b00000);
        add(EV_MWL, 7'h00, 16'h0080, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0055, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0055, 1'b1, 5'b01000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 5'b01000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0080, 1'b1, 5'b01000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b01000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        // RSTDAA cancels queued address writes but not the MRL write in flight.
        add(EV_MRL, 7'h00, 16'h0033, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_DYN, 7'h11, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0033, 1'b1, 5'b00000);
        add(EV_VIRT, 7'h12, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0033, 1'b1, 5'b00000);
        add(EV_RST, 7'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0033, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0033, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);
        add(EV_NONE, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 5'b00000);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].ev, vq[i].addr, vq[i].addr, vq[i].len, vq[i].len, vq[i].clr);
            ack0  = vq[i].ack;
            act_t = {bus0.req, vq[i].e_req ? bus0.sel : 3'd0, vq[i].e_req ? bus0.data : 16'h0000, busy0, ovf0};
            exp_t = {vq[i].e_req, vq[i].e_sel, vq[i].e_data, vq[i].e_busy, vq[i].e_ovf};
            check($sformatf("vec%0d", i), 64'(act_t), 64'(exp_t));
            tick();
        end

        // Timeout: ack held low on the AckTimeout=4 instance.
        ack1 = 1'b0;
        do_reset();
        drive(EV_MRL, 7'h00, 7'h00, 16'h0000, 16'h0077, 1'b0);
        tick();
        drive(EV_NONE, 7'h00, 7'h00, 16'h0000, 16'h0000, 1'b0);
        hi_cnt = 0;
        first_hi = -1;
        for (int i = 1; i <= 12; i++) begin
            if (bus1.req === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
            tick();
        end
        check("tmo_first_req_cycle", 64'(first_hi), 64'd2);
        check("tmo_req_cycles", 64'(hi_cnt), 64'd4);
        check("tmo_flags", {bus1.req, tout1, busy1}, {1'b0, 1'b1, 1'b0});
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("tmo_clear", 64'(tout1), 64'd0);

        // Ack in the final timeout cycle is a success.
        do_reset();
        drive(EV_MRL, 7'h00, 7'h00, 16'h0000, 16'h0078, 1'b0);
        tick();
        drive(EV_NONE, 7'h00, 7'h00, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        tick();
        tick();
        check("late_ack_req", {bus1.req, bus1.sel, bus1.data}, {1'b1, 3'd4, 16'h0078});
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        check("late_ack_no_tmo", {bus1.req, tout1, busy1}, {1'b0, 1'b0, 1'b0});

        // Reset with a request outstanding and two kinds pending.
        ack0 = 1'b0;
        do_reset();
        drive(EV_MRL, 7'h00, 7'h00, 16'h0000, 16'h0021, 1'b0);
        tick();
        drive(EV_NONE, 7'h00, 7'h00, 16'h0000, 16'h0000, 1'b0);
        tick();
        check("rst_mid_req_pre", {bus0.req, bus0.sel}, {1'b1, 3'd4});
        drive(EV_DYN | EV_MWL, 7'h33, 7'h00, 16'h0444, 16'h0000, 1'b0);
        tick();
        drive(EV_NONE, 7'h00, 7'h00, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_req_outs", {bus0.req, bus0.sel, bus0.data, busy0, ovf0, tout0}, 64'd0);
        ack0 = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus0.req === 1'b1) hi_cnt++;
            tick();
        end
        check("rst_no_req_after", 64'(hi_cnt), 64'd0);

        // Randomized events and ack against the reference model.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            m_pend[k] = 1'b0;
            m_val[k]  = 16'h0000;
        end
        m_fly = 1'b0; m_sel = 3'd0; m_data = 16'h0000; m_ovf = 5'b00000;
        for (int c = 0; c < 400; c++) begin
            logic [4:0]  ev;
            logic [6:0]  ra, rva;
            logic [15:0] rw, rr;
            logic        rc, any_pend;
            int          win;
            for (int k = 0; k < 5; k++) ev[k] = ($urandom_range(7) == 0);
            ra  = 7'($urandom);
            rva = 7'($urandom);
            rw  = 16'($urandom);
            rr  = 16'($urandom);
            rc  = ($urandom_range(15) == 0);
            drive(ev, ra, rva, rw, rr, rc);
            ack0 = 1'($urandom);

            any_pend = 1'b0;
            for (int k = 0; k < 5; k++) any_pend |= m_pend[k];
            act_t = {bus0.req, m_fly ? bus0.sel : 3'd0, m_fly ? bus0.data : 16'h0000, busy0, ovf0};
            exp_t = {m_fly, m_fly ? m_sel : 3'd0, m_fly ? m_data : 16'h0000, m_fly | any_pend, m_ovf};
            check($sformatf("rand%0d", c), 64'(act_t), 64'(exp_t));

            // A new write starts only from an idle port, picking the lowest pending kind.
            win = -1;
            if (!m_fly) begin
                for (int k = 4; k >= 0; k--) if (m_pend[k]) win = k;
            end
            if (rc) m_ovf = 5'b00000;
            for (int k = 0; k < 5; k++) begin
                if (ev[k] && m_pend[k] && (win != k) && !(ev[0] && (k == 1 || k == 2)))
                    m_ovf[k] = 1'b1;
            end
            if (win >= 0) begin
                m_fly  = 1'b1;
                m_sel  = 3'(win);
                m_data = m_val[win];
            end else if (m_fly && ack0) begin
                m_fly = 1'b0;
            end
            for (int k = 0; k < 5; k++) begin
                if (ev[k]) begin
                    m_pend[k] = 1'b1;
                    m_val[k]  = payload(k, ra, rva, rw, rr);
                end else if (k == win || (ev[0] && (k == 1 || k == 2))) begin
                    m_pend[k] = 1'b0;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
